// File: rtl/wb_fabric_pkg.sv
// rtl/wb_fabric_pkg.sv - shared types and constants for the Wishbone slave fabric
package wb_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_TOCOUNT = 2'd1;
    localparam logic [1:0] REG_ID      = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam logic [31:0] ERR_DATA   = 32'hBAD0_0000;
    localparam logic [15:0] TO_DATA_HI = 16'hDEAD;

    localparam int IDX_LSB = 16;
    localparam int IDX_W   = 4;

endpackage

// File: rtl/wb_fabric_regs.sv
// rtl/wb_fabric_regs.sv - local status/id registers with sticky timeout flag and count
module wb_fabric_regs
    import wb_fabric_pkg::*;
#(
    parameter int NUM_SLAVES     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_i,
    input  logic              we_i,
    input  logic [1:0]        off_i,
    input  logic              clr_bit_i,
    input  logic              to_set_i,
    input  logic [IDX_W-1:0]  to_idx_i,
    output logic [31:0]       rdat_o,
    output logic              irq_o
);

    logic              flag_q, flag_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]  tidx_q, tidx_d;
    logic              clr;

    always_comb begin
        clr    = acc_i && we_i && (off_i == REG_STATUS) && clr_bit_i;
        flag_d = flag_q;
        cnt_d  = cnt_q;
        tidx_d = tidx_q;
        // a timeout landing in the same cycle as a clear must stay visible
        if (to_set_i) begin
            flag_d = 1'b1;
            tidx_d = to_idx_i;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (clr) begin
            flag_d = 1'b0;
        end
    end

    always_comb begin
        rdat_o = 32'h0;
        case (off_i)
            REG_STATUS:  rdat_o = {24'h0, tidx_q, 3'b000, flag_q};
            REG_TOCOUNT: rdat_o = {16'h0, cnt_q};
            REG_ID:      rdat_o = {8'h0, 8'(NUM_SLAVES), 16'(TIMEOUT_CYCLES)};
            REG_RSVD:    rdat_o = 32'h0;
            default:     rdat_o = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
            cnt_q  <= 16'h0;
            tidx_q <= '0;
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
            tidx_q <= tidx_d;
        end
    end

    assign irq_o = flag_q;

endmodule

// File: rtl/wb_slave_fabric.sv
// rtl/wb_slave_fabric.sv - decodes master requests onto one of NUM_SLAVES slaves with timeout watchdog
module wb_slave_fabric
    import wb_fabric_pkg::*;
#(
    parameter int          NUM_SLAVES     = 3,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  BASE_HI        = 8'h30
) (
    input  logic                     wb_clk_i,
    input  logic                     nrst,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [3:0]               s_sel_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [32*NUM_SLAVES-1:0] s_dat_i,
    output logic                     irq_o
);

    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic [NUM_SLAVES-1:0]  stb_q, stb_d;
    logic                   we_q, we_d;
    logic [3:0]             sel_q, sel_d;
    logic [31:0]            adr_q, adr_d;
    logic [31:0]            wdat_q, wdat_d;

    logic [IDX_W-1:0]       req_idx;
    logic                   base_ok, is_local, is_slave;
    logic                   sel_ack, to_hit, loc_acc, to_set;
    logic [31:0]            sel_dat, loc_rdat;
    logic [NUM_SLAVES-1:0]  req_onehot;

    always_comb begin
        req_idx  = wbs_adr_i[IDX_LSB +: IDX_W];
        base_ok  = (wbs_adr_i[31:24] == BASE_HI);
        is_local = base_ok && (req_idx == '0);
        is_slave = base_ok && (req_idx != '0) && ({28'd0, req_idx} <= 32'(NUM_SLAVES));
        to_hit   = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
        sel_ack  = 1'b0;
        sel_dat  = 32'h0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            req_onehot[k] = (req_idx == IDX_W'(k + 1));
            if (idx_q == IDX_W'(k + 1)) begin
                sel_ack = s_ack_i[k];
                sel_dat = s_dat_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        loc_acc = 1'b0;
        to_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    we_d   = wbs_we_i;
                    sel_d  = wbs_sel_i;
                    adr_d  = wbs_adr_i;
                    wdat_d = wbs_dat_i;
                    idx_d  = req_idx;
                    if (is_slave) begin
                        state_d = ST_FWD;
                        stb_d   = req_onehot;
                        cnt_d   = 16'h0;
                    end else begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        loc_acc = is_local;
                        dat_d   = is_local ? loc_rdat : ERR_DATA;
                    end
                end
            end
            ST_FWD: begin
                // abort beats ack, and ack beats the watchdog
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                    stb_d   = '0;
                end else if (sel_ack) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    dat_d   = sel_dat;
                    stb_d   = '0;
                end else if (to_hit) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    dat_d   = {TO_DATA_HI, 12'h000, idx_q};
                    stb_d   = '0;
                    to_set  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                dat_d   = 32'h0;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'h0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 32'h0;
            wdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
        end
    end

    wb_fabric_regs #(
        .NUM_SLAVES     (NUM_SLAVES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_regs (
        .clk       (wb_clk_i),
        .rst_n     (nrst),
        .acc_i     (loc_acc),
        .we_i      (wbs_we_i),
        .off_i     (wbs_adr_i[3:2]),
        .clr_bit_i (wbs_dat_i[0] & wbs_sel_i[0]),
        .to_set_i  (to_set),
        .to_idx_i  (idx_q),
        .rdat_o    (loc_rdat),
        .irq_o     (irq_o)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign s_cyc_o   = stb_q;
    assign s_stb_o   = stb_q;
    assign s_we_o    = we_q;
    assign s_sel_o   = sel_q;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = wdat_q;

endmodule

// File: tb/tb_wb_slave_fabric.sv
// tb/tb_wb_slave_fabric.sv - directed self-checking bench for wb_slave_fabric
module tb_wb_slave_fabric;

    localparam int NS = 3;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic [NS-1:0] s_cyc_o, s_stb_o;
    logic          s_we_o;
    logic [3:0]    s_sel_o;
    logic [31:0]   s_adr_o, s_dat_o;
    logic [NS-1:0] s_ack;
    logic [32*NS-1:0] s_dat;
    logic          irq_o;

    int tests = 0;
    int fails = 0;

    // expectations for the current cycle, and the bench's own view of fabric state
    bit            chk_en = 1'b0;
    logic          exp_ack;
    logic [31:0]   exp_dat;
    logic [NS-1:0] exp_stb;
    logic          exp_irq;
    logic          m_we;
    logic [3:0]    m_sel;
    logic [31:0]   m_adr, m_dat;
    logic          m_flag;
    logic [3:0]    m_tidx;
    logic [15:0]   m_cnt;
    logic [31:0]   got;

    wb_slave_fabric #(
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (TO),
        .BASE_HI        (8'h30)
    ) dut (
        .wb_clk_i  (clk),
        .nrst      (nrst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_ack_i   (s_ack),
        .s_dat_i   (s_dat),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return {24'h0, m_tidx, 3'b000, m_flag};
            2'd1:    return {16'h0, m_cnt};
            2'd2:    return {8'h0, 8'(NS), 16'(TO)};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("ack", {31'h0, wbs_ack_o}, {31'h0, exp_ack});
            if (exp_ack) chk("rdata", wbs_dat_o, exp_dat);
            chk("s_stb", 32'(s_stb_o), 32'(exp_stb));
            chk("s_cyc", 32'(s_cyc_o), 32'(exp_stb));
            chk("irq", {31'h0, irq_o}, {31'h0, exp_irq});
            chk("s_we", {31'h0, s_we_o}, {31'h0, m_we});
            chk("s_sel", {28'h0, s_sel_o}, {28'h0, m_sel});
            chk("s_adr", s_adr_o, m_adr);
            chk("s_dat", s_dat_o, m_dat);
        end
    end

    task automatic model_reset();
        m_we = 1'b0; m_sel = 4'h0; m_adr = 32'h0; m_dat = 32'h0;
        m_flag = 1'b0; m_tidx = 4'h0; m_cnt = 16'h0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        exp_ack = 1'b0; exp_stb = '0; exp_irq = m_flag;
    endtask

    task automatic start_req(input logic [31:0] a, input logic w, input logic [3:0] sl, input logic [31:0] d);
        @(negedge clk);
        exp_ack = 1'b0; exp_stb = '0; exp_irq = m_flag;
        cyc = 1'b1; stb = 1'b1; we = w; sel = sl; adr = a; wdat = d;
        @(negedge clk);
        m_we = w; m_sel = sl; m_adr = a; m_dat = d;
    endtask

    // ack_at: FWD cycle (0 = first strobe cycle) in which the slave acks; negative = never
    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] sl, input logic [31:0] d,
                        input int ack_at, input logic [31:0] sd, output logic [31:0] rd);
        int idx;
        bit is_slv;
        logic [31:0] ed;
        idx = int'(a[19:16]);
        is_slv = (a[31:24] == 8'h30) && idx >= 1 && idx <= NS;
        start_req(a, w, sl, d);
        if (is_slv) begin
            for (int c = 0; c < TO; c++) begin
                exp_stb = NS'(1 << (idx - 1));
                exp_ack = 1'b0;
                exp_irq = m_flag;
                s_ack = '0;
                if (c == ack_at) begin
                    s_ack[idx-1] = 1'b1;
                    s_dat[32*(idx-1) +: 32] = sd;
                end else begin
                    s_ack[idx % NS] = 1'b1;
                end
                if (c == ack_at || c == TO - 1) break;
                @(negedge clk);
            end
            if (ack_at >= 0 && ack_at < TO) begin
                ed = sd;
            end else begin
                ed = 32'hDEAD_0000 | 32'(idx);
                m_flag = 1'b1;
                m_tidx = 4'(idx);
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            @(negedge clk);
            s_ack = '0;
        end else if (a[31:24] == 8'h30 && idx == 0) begin
            ed = m_read(a[3:2]);
            if (w && sl[0] && d[0] && a[3:2] == 2'd0) m_flag = 1'b0;
        end else begin
            ed = 32'hBAD0_0000;
        end
        exp_ack = 1'b1; exp_dat = ed; exp_stb = '0; exp_irq = m_flag;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        #2 rd = wbs_dat_o;
    endtask

    task automatic abort_xfer(input logic [31:0] a);
        int idx;
        idx = int'(a[19:16]);
        start_req(a, 1'b0, 4'hF, 32'h0);
        exp_stb = NS'(1 << (idx - 1)); exp_irq = m_flag;
        @(negedge clk);
        exp_stb = NS'(1 << (idx - 1));
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 4; i++) idle_cycle();
    endtask

    task automatic reset_mid_fwd(input logic [31:0] a);
        int idx;
        idx = int'(a[19:16]);
        start_req(a, 1'b1, 4'hF, 32'h5555_AAAA);
        exp_stb = NS'(1 << (idx - 1)); exp_irq = m_flag;
        @(negedge clk);
        exp_stb = NS'(1 << (idx - 1));
        #3;
        chk_en = 1'b0;
        nrst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        #1;
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_stb", 32'(s_stb_o), 32'h0);
        chk("rst_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_we", {31'h0, s_we_o}, 32'h0);
        chk("rst_adr", s_adr_o, 32'h0);
        chk("rst_sdat", s_dat_o, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        exp_ack = 1'b0; exp_stb = '0; exp_irq = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) idle_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; wdat = 32'h0; s_ack = '0;
        s_dat = {32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001};
        model_reset();
        exp_ack = 1'b0; exp_stb = '0; exp_irq = 1'b0; exp_dat = 32'h0;
        #12;
        chk("reset_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("reset_dat", wbs_dat_o, 32'h0);
        chk("reset_stb", 32'(s_stb_o), 32'h0);
        chk("reset_sel", {28'h0, s_sel_o}, 32'h0);
        chk("reset_irq", {31'h0, irq_o}, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        chk_en = 1'b1;
        idle_cycle();

        xfer(32'h3002_0000, 1'b0, 4'hF, 32'h0, 2, 32'h1234_5678, got);
        chk("slave_read", got, 32'h1234_5678);
        xfer(32'h3003_0010, 1'b0, 4'hF, 32'h0, 0, 32'hAAAA_5555, got);
        chk("zero_wait", got, 32'hAAAA_5555);
        xfer(32'h3007_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("invalid_idx", got, 32'hBAD0_0000);
        xfer(32'h3101_0000, 1'b1, 4'hF, 32'h1, 0, 32'h0, got);
        chk("invalid_base", got, 32'hBAD0_0000);
        xfer(32'h3001_0040, 1'b1, 4'b0011, 32'hCAFE_F00D, 3, 32'h0000_0077, got);
        chk("slave_write", got, 32'h0000_0077);
        xfer(32'h3000_0008, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("id_reg", got, 32'h0003_0008);
        xfer(32'h3000_000C, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("rsvd_reg", got, 32'h0);

        xfer(32'h3001_0000, 1'b0, 4'hF, 32'h0, -1, 32'h0, got);
        chk("timeout_data", got, 32'hDEAD_0001);
        chk("timeout_irq", {31'h0, irq_o}, 32'h1);
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("status_after_to", got, 32'h0000_0011);
        xfer(32'h3000_0004, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("tocount_1", got, 32'h1);

        xfer(32'h3002_0000, 1'b0, 4'hF, 32'h0, TO - 1, 32'h5A5A_0007, got);
        chk("ack_at_expiry", got, 32'h5A5A_0007);
        xfer(32'h3000_0004, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("tocount_same", got, 32'h1);

        xfer(32'h3000_0000, 1'b1, 4'hF, 32'h1, 0, 32'h0, got);
        chk("irq_cleared", {31'h0, irq_o}, 32'h0);

        abort_xfer(32'h3003_0000);
        xfer(32'h3000_0004, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("tocount_after_abort", got, 32'h1);

        xfer(32'h3003_0000, 1'b0, 4'hF, 32'h0, -1, 32'h0, got);
        chk("timeout_data3", got, 32'hDEAD_0003);
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("status_idx3", got, 32'h0000_0031);

        reset_mid_fwd(32'h3002_0000);
        xfer(32'h3000_0004, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("tocount_reset", got, 32'h0);
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, got);
        chk("status_reset", got, 32'h0);
        idle_cycle();
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
